// File: rtl/bus_bb_pkg.sv
// Shared definitions for the bb system bus: default widths, transfer mode
// encodings and the slave responder state type.
package bus_bb_pkg;

  localparam int DEFAULT_ADDR_W = 16;
  localparam int DEFAULT_DATA_W = 8;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } slave_state_t;

endpackage

// File: rtl/slave_bb_mem.sv
// Local byte store for the bb slave: one synchronous write port, one
// registered read port whose output holds until the next read.
module slave_bb_mem #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         re,
  input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]            rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Reset clears every entry so an aborted transfer leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/slave_bb.sv
// bb bus responder: decodes its address window, inserts a fixed number of
// wait states, then completes the captured transfer with a one-cycle ready.
module slave_bb
  import bus_bb_pkg::*;
#(
  parameter int                ADDR_W      = DEFAULT_ADDR_W,
  parameter int                DATA_W      = DEFAULT_DATA_W,
  parameter int                MEM_DEPTH   = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(16'h1000),
  parameter int                WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sl_address,
  input  logic [DATA_W-1:0] sl_wdata,
  input  logic              sl_mode,
  input  logic              m_valid,
  output logic              ready,
  output logic [DATA_W-1:0] rdata
);

  localparam int                IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0]   WIN_LO    = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0]   WIN_HI    = WIN_LO + (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  slave_state_t      state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_in, acc_idx;
  logic [DATA_W-1:0] wdata_q, acc_wdata;
  logic              mode_q, acc_mode;
  logic              in_window, start, capture, go;
  logic              mem_we, mem_re, ready_q;

  // Widened compare so a window ending at the top of the address space works.
  assign in_window = ({1'b0, sl_address} >= WIN_LO) && ({1'b0, sl_address} < WIN_HI);
  assign idx_in    = IDX_W'(sl_address - BASE_ADDR);
  assign start     = m_valid && in_window;

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    capture   = 1'b0;
    go        = 1'b0;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_mode  = mode_q;
    case (state)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            // No wait states: the access uses the live request directly.
            state_d   = RESP;
            go        = 1'b1;
            acc_idx   = idx_in;
            acc_wdata = sl_wdata;
            acc_mode  = sl_mode;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_d = RESP;
          go      = 1'b1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_we = go && (acc_mode == MODE_WRITE);
    mem_re = go && (acc_mode == MODE_READ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      mode_q  <= MODE_READ;
      ready_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      ready_q <= (state_d == RESP);
      if (capture) begin
        idx_q   <= idx_in;
        wdata_q <= sl_wdata;
        mode_q  <= sl_mode;
      end
    end
  end

  slave_bb_mem #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (acc_idx),
    .wdata (acc_wdata),
    .re    (mem_re),
    .raddr (acc_idx),
    .rdata (rdata)
  );

  assign ready = ready_q;

endmodule

// File: tb/tb_slave_bb.sv
// Bench for slave_bb: a WAIT_CYCLES=1 and a WAIT_CYCLES=0 instance, each
// checked every cycle against a transaction-level model, plus directed cases.
module tb_slave_bb;
  import bus_bb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] in_addr  [2];
  logic [7:0]  in_wdata [2];
  logic        in_mode  [2];
  logic        in_valid [2];
  logic        rdy0, rdy1;
  logic [7:0]  rd0, rd1;

  int checks = 0;
  int passes = 0;

  slave_bb #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .sl_address(in_addr[0]), .sl_wdata(in_wdata[0]),
    .sl_mode(in_mode[0]), .m_valid(in_valid[0]), .ready(rdy0), .rdata(rd0)
  );

  slave_bb #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .sl_address(in_addr[1]), .sl_wdata(in_wdata[1]),
    .sl_mode(in_mode[1]), .m_valid(in_valid[1]), .ready(rdy1), .rdata(rd1)
  );

  function automatic logic get_ready(input int k);
    return (k == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic [7:0] get_rdata(input int k);
    return (k == 0) ? rd0 : rd1;
  endfunction

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // Transaction-level model: phase 0 idle, 1 counting wait states, 2 responding.
  logic [7:0] mdl_mem   [2][256];
  int         mdl_phase [2];
  int         mdl_left  [2];
  logic [7:0] mdl_idx   [2];
  logic [7:0] mdl_data  [2];
  logic       mdl_wr    [2];
  logic       mdl_ready [2];
  logic [7:0] mdl_rdata [2];

  function automatic bit in_window(input logic [15:0] a);
    int off;
    off = int'(a) - 4096;
    return (off >= 0) && (off < 256);
  endfunction

  task automatic model_finish(input int k);
    if (mdl_wr[k]) mdl_mem[k][mdl_idx[k]] = mdl_data[k];
    else           mdl_rdata[k] = mdl_mem[k][mdl_idx[k]];
    mdl_ready[k] = 1'b1;
    mdl_phase[k] = 2;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 256; i++) mdl_mem[k][i] = 8'h00;
        mdl_phase[k] = 0;
        mdl_left[k]  = 0;
        mdl_ready[k] = 1'b0;
        mdl_rdata[k] = 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mdl_ready[k] = 1'b0;
        case (mdl_phase[k])
          0: if (in_valid[k] && in_window(in_addr[k])) begin
               mdl_idx[k]  = 8'(int'(in_addr[k]) - 4096);
               mdl_data[k] = in_wdata[k];
               mdl_wr[k]   = (in_mode[k] == MODE_WRITE);
               if (wait_of(k) == 0) model_finish(k);
               else begin
                 mdl_left[k]  = wait_of(k);
                 mdl_phase[k] = 1;
               end
             end
          1: begin
               mdl_left[k]--;
               if (mdl_left[k] == 0) model_finish(k);
             end
          default: mdl_phase[k] = 0;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("ready_w1", 32'(rdy0), 32'(mdl_ready[0]));
    checkOutput("rdata_w1", 32'(rd0),  32'(mdl_rdata[0]));
    checkOutput("ready_w0", 32'(rdy1), 32'(mdl_ready[1]));
    checkOutput("rdata_w0", 32'(rd1),  32'(mdl_rdata[1]));
  end

  task automatic drive(input int k, input logic [15:0] a, input logic [7:0] d,
                       input logic m, input logic v);
    in_addr[k]  = a;
    in_wdata[k] = d;
    in_mode[k]  = m;
    in_valid[k] = v;
  endtask

  // Issues one transfer from a negedge, returns latency in cycles (-1 on timeout).
  task automatic applyStimulus(input int k, input logic [15:0] a, input logic [7:0] d,
                               input logic m, output int lat, output logic [7:0] rd);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    rd   = 8'h00;
    drive(k, a, d, m, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (get_ready(k)) begin
        rd   = get_rdata(k);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) lat = -1;
    drive(k, 16'h0000, 8'h00, MODE_READ, 1'b0);
    @(negedge clk);
    checkOutput("pulse_width", 32'(get_ready(k)), 32'd0);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1, 2, 3: return 16'h1000 + 16'($urandom_range(0, 7));
      4:          return 16'h10F8 + 16'($urandom_range(0, 7));
      5:          return 16'h1100 + 16'($urandom_range(0, 3));
      6:          return 16'h0FFC + 16'($urandom_range(0, 3));
      default:    return 16'($urandom);
    endcase
  endfunction

  int         lat;
  logic [7:0] rd;
  bit         seen;

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) drive(k, 16'h0000, 8'h00, MODE_READ, 1'b0);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 32'(rdy0), 32'd0);
    checkOutput("reset_rdata", 32'(rd0), 32'h00);
    #1 rst = 1'b0;
    @(negedge clk);

    applyStimulus(0, 16'h1000, 8'h00, MODE_READ, lat, rd);
    checkOutput("post_reset_read", 32'(rd), 32'h00);

    applyStimulus(0, 16'h1034, 8'hAB, MODE_WRITE, lat, rd);
    checkOutput("write_latency_w1", 32'(lat), 32'd2);
    applyStimulus(0, 16'h1034, 8'h00, MODE_READ, lat, rd);
    checkOutput("read_latency_w1", 32'(lat), 32'd2);
    checkOutput("read_1034", 32'(rd), 32'hAB);

    drive(0, 16'h1234, 8'h55, MODE_READ, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("out_of_window_ready", 32'(rdy0), 32'd0);
    end
    drive(0, 16'h0000, 8'h00, MODE_READ, 1'b0);
    @(negedge clk);
    applyStimulus(0, 16'h1034, 8'h00, MODE_READ, lat, rd);
    checkOutput("mem_unchanged", 32'(rd), 32'hAB);

    applyStimulus(0, 16'h10FF, 8'h5A, MODE_WRITE, lat, rd);
    checkOutput("top_edge_latency", 32'(lat), 32'd2);
    applyStimulus(0, 16'h10FF, 8'h00, MODE_READ, lat, rd);
    checkOutput("top_edge_read", 32'(rd), 32'h5A);
    drive(0, 16'h1100, 8'h77, MODE_WRITE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("past_edge_ready", 32'(rdy0), 32'd0);
    end
    drive(0, 16'h0000, 8'h00, MODE_READ, 1'b0);
    @(negedge clk);

    applyStimulus(0, 16'h1005, 8'hEF, MODE_WRITE, lat, rd);
    applyStimulus(0, 16'h1005, 8'h00, MODE_READ, lat, rd);
    checkOutput("b2b_read_w1", 32'(rd), 32'hEF);
    applyStimulus(1, 16'h1005, 8'hEF, MODE_WRITE, lat, rd);
    checkOutput("write_latency_w0", 32'(lat), 32'd1);
    applyStimulus(1, 16'h1005, 8'h00, MODE_READ, lat, rd);
    checkOutput("read_latency_w0", 32'(lat), 32'd1);
    checkOutput("b2b_read_w0", 32'(rd), 32'hEF);

    drive(0, 16'h1010, 8'h12, MODE_WRITE, 1'b1);
    @(negedge clk);
    drive(0, 16'h1011, 8'h99, MODE_READ, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy0) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("late_change_ready", 32'(seen), 32'd1);
    @(negedge clk);
    applyStimulus(0, 16'h1010, 8'h00, MODE_READ, lat, rd);
    checkOutput("late_change_data", 32'(rd), 32'h12);

    drive(0, 16'h10AD, 8'hBE, MODE_WRITE, 1'b1);
    @(negedge clk);
    #1 rst = 1'b1;
    drive(0, 16'h0000, 8'h00, MODE_READ, 1'b0);
    @(negedge clk);
    checkOutput("reset_mid_ready", 32'(rdy0), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_mid_ready_after", 32'(rdy0), 32'd0);
    applyStimulus(0, 16'h10AD, 8'h00, MODE_READ, lat, rd);
    checkOutput("reset_mid_data", 32'(rd), 32'h00);
    applyStimulus(0, 16'h1034, 8'h00, MODE_READ, lat, rd);
    checkOutput("reset_cleared_mem", 32'(rd), 32'h00);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        drive(k, rand_addr(), 8'($urandom), 1'($urandom), ($urandom_range(0, 9) < 6));
      end
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) drive(k, 16'h0000, 8'h00, MODE_READ, 1'b0);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
